// File: rtl/led_sweep_sequencer.sv
// Position sequencer for the addressable-LED strip driver: bounce, wrap-forward, single-shot and wrap-reverse sweeps.
// Optional macro LED_SWEEP_WATCHDOG_EN adds TIMEOUT_CYCLES and a sticky frame_timeout output.
module led_sweep_sequencer #(
    parameter int unsigned NUM_LEDS    = 51,
    parameter int unsigned BASE_CYCLES = 1000000,
    parameter int unsigned MIN_HOLD    = 5000,
    parameter int unsigned CNT_W       = 16
`ifdef LED_SWEEP_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
`endif
) (
    input  logic                        clk_100mhz,
    input  logic                        sys_rst_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic [1:0]                  mode,
    input  logic [3:0]                  period_sel,
    input  logic                        frame_done,
    output logic [$clog2(NUM_LEDS)-1:0] position,
    output logic                        is_forward,
    output logic                        frame_start,
    output logic                        busy,
    output logic                        run_done,
    output logic [CNT_W-1:0]            sweep_count
`ifdef LED_SWEEP_WATCHDOG_EN
    ,
    output logic                        frame_timeout
`endif
);

    localparam int unsigned POS_W    = $clog2(NUM_LEDS);
    localparam int unsigned HOLD_MAX = (BASE_CYCLES * 16 > MIN_HOLD) ? BASE_CYCLES * 16 : MIN_HOLD;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [POS_W-1:0] LAST = POS_W'(NUM_LEDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_WRAP_F = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;
    localparam logic [1:0] MODE_WRAP_R = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [3:0]        period_q, period_d;
    logic              stop_pend_q, stop_pend_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              fwd_q, fwd_d;
    logic              fstart_q, fstart_d;
    logic              run_done_q, run_done_d;
    logic [CNT_W-1:0]  sweep_q, sweep_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] hold_scaled, hold_calc;

`ifdef LED_SWEEP_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    // Hold period uses the period_sel latched at start so mid-run changes are ignored.
    assign hold_scaled = HOLD_W'(BASE_CYCLES) * (HOLD_W'(period_q) + HOLD_W'(1));
    assign hold_calc   = (hold_scaled < HOLD_W'(MIN_HOLD)) ? HOLD_W'(MIN_HOLD) : hold_scaled;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        period_d    = period_q;
        stop_pend_d = stop_pend_q;
        pos_d       = pos_q;
        fwd_d       = fwd_q;
        fstart_d    = 1'b0;
        run_done_d  = 1'b0;
        sweep_d     = sweep_q;
        hold_d      = hold_q;
        hold_cnt_d  = hold_cnt_q;
`ifdef LED_SWEEP_WATCHDOG_EN
        wd_cnt_d    = wd_cnt_q;
        timeout_d   = timeout_q;
`endif

        if (state_q != S_IDLE && stop) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    period_d    = period_sel;
                    stop_pend_d = stop;
                    sweep_d     = '0;
                    state_d     = S_SEND;
                    fstart_d    = 1'b1;
                    if (mode == MODE_WRAP_R) begin
                        pos_d = LAST;
                        fwd_d = 1'b0;
                    end else begin
                        pos_d = '0;
                        fwd_d = 1'b1;
                    end
`ifdef LED_SWEEP_WATCHDOG_EN
                    wd_cnt_d  = '0;
                    timeout_d = 1'b0;
`endif
                end
            end

            S_SEND: begin
                if (frame_done) begin
                    hold_d     = hold_calc;
                    hold_cnt_d = '0;
                    state_d    = S_HOLD;
                end
`ifdef LED_SWEEP_WATCHDOG_EN
                else if (wd_cnt_q == WD_LAST) begin
                    state_d    = S_IDLE;
                    run_done_d = 1'b1;
                    timeout_d  = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
`endif
            end

            S_HOLD: begin
                if (hold_cnt_q != hold_q - HOLD_W'(1)) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end else if (stop_pend_q) begin
                    state_d    = S_IDLE;
                    run_done_d = 1'b1;
                end else begin
                    state_d  = S_SEND;
                    fstart_d = 1'b1;
`ifdef LED_SWEEP_WATCHDOG_EN
                    wd_cnt_d = '0;
`endif
                    case (mode_q)
                        MODE_BOUNCE: begin
                            // Endpoints turn around in place so each end is shown once per pass.
                            if (fwd_q) begin
                                if (pos_q == LAST) begin
                                    pos_d   = LAST - POS_W'(1);
                                    fwd_d   = 1'b0;
                                    sweep_d = sweep_q + CNT_W'(1);
                                end else begin
                                    pos_d = pos_q + POS_W'(1);
                                end
                            end else begin
                                if (pos_q == '0) begin
                                    pos_d   = POS_W'(1);
                                    fwd_d   = 1'b1;
                                    sweep_d = sweep_q + CNT_W'(1);
                                end else begin
                                    pos_d = pos_q - POS_W'(1);
                                end
                            end
                        end
                        MODE_WRAP_F: begin
                            if (pos_q == LAST) begin
                                pos_d   = '0;
                                sweep_d = sweep_q + CNT_W'(1);
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                            end
                        end
                        MODE_SINGLE: begin
                            if (pos_q == LAST) begin
                                state_d    = S_IDLE;
                                fstart_d   = 1'b0;
                                run_done_d = 1'b1;
                                sweep_d    = CNT_W'(1);
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                            end
                        end
                        MODE_WRAP_R: begin
                            if (pos_q == '0) begin
                                pos_d   = LAST;
                                sweep_d = sweep_q + CNT_W'(1);
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                            end
                        end
                    endcase
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            period_q    <= '0;
            stop_pend_q <= 1'b0;
            pos_q       <= '0;
            fwd_q       <= 1'b0;
            fstart_q    <= 1'b0;
            run_done_q  <= 1'b0;
            sweep_q     <= '0;
            hold_q      <= '0;
            hold_cnt_q  <= '0;
`ifdef LED_SWEEP_WATCHDOG_EN
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            period_q    <= period_d;
            stop_pend_q <= stop_pend_d;
            pos_q       <= pos_d;
            fwd_q       <= fwd_d;
            fstart_q    <= fstart_d;
            run_done_q  <= run_done_d;
            sweep_q     <= sweep_d;
            hold_q      <= hold_d;
            hold_cnt_q  <= hold_cnt_d;
`ifdef LED_SWEEP_WATCHDOG_EN
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign position    = pos_q;
    assign is_forward  = fwd_q;
    assign frame_start = fstart_q;
    assign busy        = (state_q != S_IDLE);
    assign run_done    = run_done_q;
    assign sweep_count = sweep_q;
`ifdef LED_SWEEP_WATCHDOG_EN
    assign frame_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_led_sweep_sequencer.sv
// Directed bench for led_sweep_sequencer (NUM_LEDS=4, BASE_CYCLES=10, MIN_HOLD=25); frames acknowledged 3 cycles after frame_start.
module tb_led_sweep_sequencer;

    localparam int POS_W = 2;

    logic             clk;
    logic             sys_rst_n;
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [3:0]       period_sel;
    logic             frame_done;
    logic             fd_resp;
    logic             fd_extra;
    logic             fd_en;
    logic [POS_W-1:0] position;
    logic             is_forward;
    logic             frame_start;
    logic             busy;
    logic             run_done;
    logic [15:0]      sweep_count;
`ifdef LED_SWEEP_WATCHDOG_EN
    logic             frame_timeout;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    assign frame_done = fd_resp | fd_extra;

    led_sweep_sequencer #(
        .NUM_LEDS(4),
        .BASE_CYCLES(10),
        .MIN_HOLD(25),
        .CNT_W(16)
`ifdef LED_SWEEP_WATCHDOG_EN
        , .TIMEOUT_CYCLES(50)
`endif
    ) dut (
        .clk_100mhz(clk),
        .sys_rst_n(sys_rst_n),
        .start(start),
        .stop(stop),
        .mode(mode),
        .period_sel(period_sel),
        .frame_done(frame_done),
        .position(position),
        .is_forward(is_forward),
        .frame_start(frame_start),
        .busy(busy),
        .run_done(run_done),
        .sweep_count(sweep_count)
`ifdef LED_SWEEP_WATCHDOG_EN
        , .frame_timeout(frame_timeout)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Cascade-generator model: acknowledge each frame 3 cycles after its frame_start.
    initial begin
        fd_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_start === 1'b1 && fd_en === 1'b1) begin
                repeat (3) @(negedge clk);
                fd_resp = 1'b1;
                @(negedge clk);
                fd_resp = 1'b0;
            end
        end
    end

    typedef struct {
        bit         nr;
        logic [1:0] mode;
        logic [3:0] psel;
        int         pos;
        int         fwd;
        int         sweep;
        int         gap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit nr, input int m, input int p, input int pos, input int fwd,
                       input int sw, input int gap);
        vec_t v;
        v.nr = nr; v.mode = 2'(m); v.psel = 4'(p);
        v.pos = pos; v.fwd = fwd; v.sweep = sw; v.gap = gap;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic start_run(input logic [1:0] m, input logic [3:0] p);
        mode = m; period_sel = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = m ^ 2'b01;
        period_sel = ~p;
    endtask

    task automatic wait_frame(output int t, output logic [POS_W-1:0] p, output logic f, output logic [15:0] s);
        int n = 0;
        t = -1000; p = 'x; f = 1'bx; s = 'x;
        while (n < 400 && frame_start !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        if (frame_start === 1'b1) begin
            t = cyc; p = position; f = is_forward; s = sweep_count;
            @(negedge clk);
        end else begin
            checks++;
            failures++;
            $display("FAIL wait_frame actual=timeout required=frame_start");
        end
    endtask

    task automatic wait_run_done(input int t0, input int gap, input string name);
        int n  = 0;
        int fs = 0;
        int tr = -1000;
        while (n < 300 && tr < 0) begin
            @(negedge clk);
            n++;
            if (frame_start === 1'b1) fs++;
            if (run_done === 1'b1) tr = cyc;
        end
        check({name, "_run_done_gap"}, tr - t0, gap);
        repeat (60) begin
            @(negedge clk);
            if (frame_start === 1'b1) fs++;
        end
        check({name, "_extra_frames"}, fs, 0);
        check({name, "_busy"}, busy, 0);
    endtask

    task automatic end_run();
        int n = 0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        while (n < 400 && busy === 1'b1) begin
            @(negedge clk);
            n++;
        end
        check("end_run_idle", busy, 0);
    endtask

    initial begin
        int t, tprev;
        logic [POS_W-1:0] p;
        logic f;
        logic [15:0] s;

        // mode 0, period_sel 3: hold 40, frame gap 44
        add(1, 0, 3, 0, 1, 0, 0);
        add(0, 0, 3, 1, 1, 0, 44);
        add(0, 0, 3, 2, 1, 0, 44);
        add(0, 0, 3, 3, 1, 0, 44);
        add(0, 0, 3, 2, 0, 1, 44);
        add(0, 0, 3, 1, 0, 1, 44);
        add(0, 0, 3, 0, 0, 1, 44);
        add(0, 0, 3, 1, 1, 2, 44);
        // mode 1, period_sel 0: hold clamps to 25, gap 29
        for (int i = 0; i < 10; i++) add(i == 0, 1, 0, i % 4, 1, i / 4, (i == 0) ? 0 : 29);
        // mode 3, period_sel 2: hold 30, gap 34
        for (int i = 0; i < 10; i++) add(i == 0, 3, 2, 3 - (i % 4), 0, i / 4, (i == 0) ? 0 : 34);
        // mode 2, period_sel 0
        for (int i = 0; i < 4; i++) add(i == 0, 2, 0, i, 1, 0, (i == 0) ? 0 : 29);

        sys_rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = '0; period_sel = '0;
        fd_extra = 1'b0; fd_en = 1'b1;

        repeat (3) begin
            @(negedge clk);
            start = ~start; stop = ~stop; mode = mode + 2'd1; period_sel = period_sel + 4'd5;
            fd_extra = ~fd_extra;
            #1;
            check("rst_outputs", {position, is_forward, frame_start, busy, run_done, sweep_count}, 0);
        end
        @(negedge clk);
        start = 1'b0; stop = 1'b0; mode = '0; period_sel = '0; fd_extra = 1'b0;
        sys_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_frame_start", frame_start, 0);
        check("post_rst_position", position, 0);

        tprev = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].nr) begin
                if (busy === 1'b1) end_run();
                start_run(vecs[i].mode, vecs[i].psel);
            end
            wait_frame(t, p, f, s);
            check($sformatf("v%0d_position", i), p, vecs[i].pos);
            check($sformatf("v%0d_is_forward", i), f, vecs[i].fwd);
            check($sformatf("v%0d_sweep_count", i), s, vecs[i].sweep);
            if (vecs[i].gap != 0) check($sformatf("v%0d_frame_gap", i), t - tprev, vecs[i].gap);
            tprev = t;
        end

        // Single-shot completes after the last frame's hold.
        wait_run_done(tprev, 29, "single_shot");
        check("single_shot_sweep_count", sweep_count, 1);
        check("single_shot_position", position, 3);

        // stop during SEND of position 2; a stray frame_done in HOLD must be ignored.
        start_run(2'd0, 4'd3);
        wait_frame(t, p, f, s);
        wait_frame(t, p, f, s);
        wait_frame(t, p, f, s);
        check("stop_frame_position", p, 2);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (8) @(negedge clk);
        fd_extra = 1'b1;
        @(negedge clk);
        fd_extra = 1'b0;
        wait_run_done(t, 44, "stop_mid");
        check("stop_mid_position", position, 2);

        // start and stop together: exactly one frame.
        mode = 2'd1; period_sel = 4'd0; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        wait_frame(t, p, f, s);
        check("start_stop_position", p, 0);
        wait_run_done(t, 29, "start_stop");

`ifdef LED_SWEEP_WATCHDOG_EN
        fd_en = 1'b0;
        start_run(2'd1, 4'd0);
        wait_frame(t, p, f, s);
        wait_run_done(t, 50, "watchdog");
        check("watchdog_frame_timeout", frame_timeout, 1);
        fd_en = 1'b1;
        start_run(2'd1, 4'd0);
        check("watchdog_cleared_on_start", frame_timeout, 0);
        wait_frame(t, p, f, s);
        end_run();
`endif

        // Reset in the middle of a frame clears outputs asynchronously.
        start_run(2'd1, 4'd0);
        for (int k = 0; k < 6; k++) wait_frame(t, p, f, s);
        check("pre_reset_sweep_count", s, 1);
        sys_rst_n = 1'b0;
        #1;
        check("midrun_rst_position", position, 0);
        check("midrun_rst_is_forward", is_forward, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_sweep_count", sweep_count, 0);
        @(negedge clk);
        sys_rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_midrun_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_sweep_sequencer.md
Name: led_sweep_sequencer

Overview:
- Parametrised position sequencer for the addressable-LED strip driver; successor to the fixed forward/reverse scanner in top level.
- Steps a lit position across NUM_LEDS pixels in one of four run modes, with a programmable hold period.
- Handshakes each frame with the cascade generator (frame_start / frame_done) and reports sweep progress.

Parameters:
- NUM_LEDS, 51, strip length; legal range 2..1023.
- BASE_CYCLES, 1000000, hold-period unit in clk_100mhz cycles.
- MIN_HOLD, 5000, minimum hold cycles; covers the 50 us WS2812 latch time.
- CNT_W, 16, width of sweep_count.

Ports:
- clk_100mhz  in  1  system clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; begins a run when sampled high in IDLE.
- stop  in  1  level; requests end of run.
- mode  in  2  run mode: 0 bounce, 1 wrap-forward, 2 single-shot forward, 3 wrap-reverse.
- period_sel  in  4  hold period select.
- frame_done  in  1  pulse from the cascade generator: frame fully shifted out.
- position  out  $clog2(NUM_LEDS)  index of the lit pixel.
- is_forward  out  1  1 when the current direction is increasing.
- frame_start  out  1  one-cycle pulse telling the cascade generator to transmit position.
- busy  out  1  high in every state except IDLE.
- run_done  out  1  one-cycle pulse when a run ends (stop or single-shot completion).
- sweep_count  out  CNT_W  number of completed end-to-end sweeps.

Behaviour:
- Reset (async assert, sync release), all outputs 0, state IDLE:
  - position=0, is_forward=0, frame_start=0, busy=0, run_done=0, sweep_count=0.
- States:
  - IDLE:
    - On start=1: latch mode into mode_q and clear stop_pending. mode, start and period_sel changes after this are ignored until the next IDLE.
    - Set position=NUM_LEDS-1 and is_forward=0 for mode 3; otherwise position=0 and is_forward=1.
    - Clear sweep_count. Next state is SEND.
  - SEND:
    - frame_start=1 on the first SEND cycle only; it is registered.
    - frame_done is accepted on any SEND cycle, including the first. On acceptance, latch hold_q and go to HOLD with hold_cnt=0.
    - hold_q = max(BASE_CYCLES*(1+period_sel), MIN_HOLD). Size it for BASE_CYCLES*16 without overflow.
  - HOLD:
    - Increment hold_cnt until hold_cnt==hold_q-1, so HOLD lasts exactly hold_q cycles.
    - On the last HOLD cycle, if stop_pending: go to IDLE, run_done=1 for 1 cycle, position held.
    - Otherwise compute the next position (rules below) and go to SEND.
- Next-position rules:
  - mode 0 (bounce): step by +1 or -1 according to is_forward.
    - At NUM_LEDS-1 while forward: next is NUM_LEDS-2, is_forward=0, sweep_count+1.
    - At 0 while reverse: next is 1, is_forward=1, sweep_count+1.
    - Endpoints are shown exactly once per pass.
  - mode 1 (wrap-forward): NUM_LEDS-1 -> 0, with sweep_count+1.
  - mode 2 (single-shot forward): at NUM_LEDS-1, go to IDLE instead of SEND, run_done=1, sweep_count=1.
  - mode 3 (wrap-reverse): 0 -> NUM_LEDS-1, with sweep_count+1.
- stop handling:
  - stop=1 in any non-IDLE state sets stop_pending. It takes effect only at the end of HOLD, so an in-flight frame always completes and latches.
  - stop in IDLE has no effect.
  - start and stop high together in IDLE: the run starts, stop_pending is set, and the run ends after the first frame.
- Ignored inputs:
  - frame_done outside SEND is ignored.
  - start while busy is ignored.
- sweep_count wraps modulo 2^CNT_W.
- Reset asserted mid-run forces IDLE and clears all outputs immediately, even in the middle of a frame.

Optional Feature:
- Macro: LED_SWEEP_WATCHDOG_EN.
- When defined:
  - Adds parameter TIMEOUT_CYCLES, default 2000000, and output frame_timeout (1 bit).
  - If SEND lasts TIMEOUT_CYCLES cycles without frame_done, go to IDLE and pulse run_done.
  - frame_timeout goes high and stays high (sticky) until the next accepted start or reset.
- When undefined: SEND waits indefinitely, and neither the port nor the parameter exists.

Test Plan:
Bench configuration: NUM_LEDS=4, BASE_CYCLES=10, MIN_HOLD=25, frame_done returned 3 cycles after each frame_start.
- Reset: hold sys_rst_n=0, toggle all inputs -> every output 0; deassert -> state IDLE, busy=0.
- mode 0, period_sel=3: positions 0,1,2,3,2,1,0,1. sweep_count increments at position 3 and at 0. Gap between consecutive frame_start pulses = 40+4 cycles.
- mode 1 and mode 3 for 10 frames each: mode 1 gives 0,1,2,3,0,1...; mode 3 gives 3,2,1,0,3,2...; sweep_count=2 after the 8th frame in each.
- mode 2, period_sel=0:
  - hold_q clamps to 25; positions 0..3.
  - After frame 4's HOLD: run_done pulse, busy=0, sweep_count=1.
- stop pulsed during the SEND of position 2 (mode 0): frame 2 completes its full HOLD, then IDLE with run_done; no further frame_start.
- With LED_SWEEP_WATCHDOG_EN and TIMEOUT_CYCLES=50: suppress frame_done -> after 50 SEND cycles, IDLE, frame_timeout=1, run_done pulse; the next start clears frame_timeout.
